share_filter: RTL and testbench

//  Sits downstream of dsha_finisher; upstream of uart_multibyte_transmitter.

---
 rtl/share_pkg.sv | 37 +++
 rtl/hit_fifo.sv | 74 +++++++
 rtl/share_filter.sv | 163 ++++++++++++++++
 tb/tb_share_filter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : share_pkg
// Description : Shared types, constants and frame packing for the share
//               filter (hit queue entry type and 512-bit UART frame layout).
// Revision    : 1.0 - initial release
// ============================================================================
package share_pkg;

    localparam logic [63:0] FRAME_MAGIC = 64'hdead432987beefaa;
    localparam logic [7:0]  FRAME_SEP   = 8'haa;

    localparam int HASH_LSB  = 0;
    localparam int SEP0_LSB  = 256;
    localparam int NONCE_LSB = 264;
    localparam int SEP1_LSB  = 296;
    localparam int MAGIC_LSB = 448;

    typedef struct packed {
        logic [255:0] hash;
        logic [31:0]  nonce;
    } share_t;

    // Builds the transmit frame; bits not covered by a field are zero.
    function automatic logic [511:0] pack_frame(input share_t s);
        logic [511:0] f;
        f                     = '0;
        f[HASH_LSB  +: 256]   = s.hash;
        f[SEP0_LSB  +: 8]     = FRAME_SEP;
        f[NONCE_LSB +: 32]    = s.nonce;
        f[SEP1_LSB  +: 8]     = FRAME_SEP;
        f[MAGIC_LSB +: 64]    = FRAME_MAGIC;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hit_fifo
// Description : Synchronous FIFO of share_t entries, 2**DEPTH_LOG deep.
//               A push while full is ignored unless a pop happens at the
//               same edge, in which case the freed slot takes the new entry.
// Ports       : clk, rst_n (async active-low), push/push_data, pop,
//               head (oldest entry), full, empty, count (occupancy).
// Revision    : 1.0 - initial release
// ============================================================================
module hit_fifo
    import share_pkg::*;
#(
    parameter int DEPTH_LOG = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  share_t             push_data,
    input  logic               pop,
    output share_t             head,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_LOG:0] count
);

    localparam int                 c_DEPTH    = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] c_FULL_CNT = (DEPTH_LOG + 1)'(c_DEPTH);

    share_t               r_mem [c_DEPTH];
    logic [DEPTH_LOG-1:0] r_wr_ptr;
    logic [DEPTH_LOG-1:0] r_rd_ptr;
    logic [DEPTH_LOG:0]   r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_FULL_CNT) || w_pop);

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/share_filter.sv
`default_nettype none
// ============================================================================
// Module      : share_filter
// Description : Tests each finished double-SHA hash against a runtime
//               leading-zero difficulty, queues hits with their nonce and
//               offers them one at a time as 512-bit UART frames.
// Ports       : clk, rst_n (async active-low)
//               in_valid/in_hash/in_nonce  - finished hash stream
//               zero_bits                  - required leading zero bits
//               clr_ovf                    - clears sticky overflow
//               tx_ready/tx_req/tx_data    - frame handshake to transmitter
//               overflow                   - sticky hit-dropped flag
//               hit_count/drop_count       - statistics
// Config      : SHARE_FILTER_STATS_EN - when defined, hit_count/drop_count
//               are live 32-bit wrapping counters; otherwise tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module share_filter
    import share_pkg::*;
#(
    parameter int DEPTH_LOG = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [255:0] in_hash,
    input  logic [31:0]  in_nonce,
    input  logic [7:0]   zero_bits,
    input  logic         clr_ovf,
    input  logic         tx_ready,
    output logic         tx_req,
    output logic [511:0] tx_data,
    output logic         overflow,
    output logic [31:0]  hit_count,
    output logic [31:0]  drop_count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_OFFER = 2'd1;
    localparam logic [1:0] c_ST_LOAD  = 2'd2;

    logic [1:0]         r_state;
    logic               r_tx_req;
    logic [511:0]       r_tx_data;
    logic               r_overflow;

    logic [8:0]         w_shamt;
    logic               w_hit;
    logic               w_accept;
    logic               w_push_ok;
    logic               w_drop;
    share_t             w_in_share;
    share_t             w_head;
    logic               w_full;
    logic               w_empty;
    logic [DEPTH_LOG:0] w_count;

    // Shifting by 256 (zero_bits == 0) yields zero, so every valid input hits.
    assign w_shamt    = 9'd256 - {1'b0, zero_bits};
    assign w_hit      = in_valid && ((in_hash >> w_shamt) == 256'd0);
    assign w_accept   = r_tx_req && tx_ready;
    // A same-edge accept frees a slot, so a full FIFO can still take the hit.
    assign w_push_ok  = w_hit && (!w_full || w_accept);
    assign w_drop     = w_hit && w_full && !w_accept;
    assign w_in_share = '{hash: in_hash, nonce: in_nonce};

    hit_fifo #(
        .DEPTH_LOG (DEPTH_LOG)
    ) u_hit_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_hit),
        .push_data (w_in_share),
        .pop       (w_accept),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Offer FSM. After an accept, tx_req drops for one cycle before the next
    // head is loaded, giving the transmitter a clean frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_tx_data <= pack_frame(w_head);
                        r_tx_req  <= 1'b1;
                        r_state   <= c_ST_OFFER;
                    end
                end
                c_ST_OFFER: begin
                    if (w_accept) begin
                        r_tx_req <= 1'b0;
                        // Something remains if more than the popped entry was
                        // queued, or a new hit lands at this same edge.
                        if ((w_count > {{DEPTH_LOG{1'b0}}, 1'b1}) || w_push_ok) begin
                            r_state <= c_ST_LOAD;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_LOAD: begin
                    r_tx_data <= pack_frame(w_head);
                    r_tx_req  <= 1'b1;
                    r_state   <= c_ST_OFFER;
                end
                default: begin
                    r_tx_req <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Setting takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef SHARE_FILTER_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_drop) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign drop_count = r_drop_count;
`else
    assign hit_count  = 32'd0;
    assign drop_count = 32'd0;
`endif

    assign tx_req   = r_tx_req;
    assign tx_data  = r_tx_data;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_share_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_share_filter
// Description : Self-checking bench for share_filter. A queue-based model
//               predicts tx_req/tx_data/overflow/stats each cycle; directed
//               scenarios are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_share_filter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [255:0] in_hash;
    logic [31:0]  in_nonce;
    logic [7:0]   zero_bits;
    logic         clr_ovf;
    logic         tx_ready;
    logic         tx_req;
    logic [511:0] tx_data;
    logic         overflow;
    logic [31:0]  hit_count;
    logic [31:0]  drop_count;

    share_filter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_hash    (in_hash),
        .in_nonce   (in_nonce),
        .zero_bits  (zero_bits),
        .clr_ovf    (clr_ovf),
        .tx_ready   (tx_ready),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .overflow   (overflow),
        .hit_count  (hit_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [255:0] mq_hash[$];
    logic [31:0]  mq_nonce[$];
    logic         m_req;
    logic [511:0] m_data;
    logic         m_ovf;
    logic [31:0]  m_hits;
    logic [31:0]  m_drops;
    logic [31:0]  dut_sent[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int lead_zeros(input logic [255:0] h);
        for (int i = 255; i >= 0; i--) begin
            if (h[i]) return 255 - i;
        end
        return 256;
    endfunction

    function automatic logic [511:0] frame(input logic [255:0] h, input logic [31:0] n);
        return {64'hdead432987beefaa, 144'd0, 8'haa, n, 8'haa, h};
    endfunction

    function automatic logic [31:0] exp_stat(input logic [31:0] v);
`ifdef SHARE_FILTER_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    function automatic logic [255:0] hit_hash();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
        h[255:240] = 16'h0;
        return h;
    endfunction

    task automatic model_reset();
        mq_hash.delete();
        mq_nonce.delete();
        m_req   = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_hits  = '0;
        m_drops = '0;
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic cyc(input logic v, input logic [255:0] h, input logic [31:0] n,
                       input logic [7:0] zb, input logic rdy, input logic clr);
        int   sz;
        logic acc;
        logic hit;
        in_valid  = v;
        in_hash   = h;
        in_nonce  = n;
        zero_bits = zb;
        tx_ready  = rdy;
        clr_ovf   = clr;
        #1;
        if (tx_req && tx_ready) dut_sent.push_back(tx_data[295:264]);
        sz  = mq_hash.size();
        acc = m_req && rdy;
        hit = v && (lead_zeros(h) >= int'(zb));
        if (acc) begin
            m_req = 1'b0;
        end else if (!m_req && sz > 0) begin
            m_req  = 1'b1;
            m_data = frame(mq_hash[0], mq_nonce[0]);
        end
        if (acc) begin
            void'(mq_hash.pop_front());
            void'(mq_nonce.pop_front());
        end
        if (hit && (sz < 4 || acc)) begin
            mq_hash.push_back(h);
            mq_nonce.push_back(n);
            m_hits++;
        end else if (hit) begin
            m_ovf = 1'b1;
            m_drops++;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        if (hit && sz == 4 && !acc) begin
            // drop already recorded; set wins over clear
        end else if (clr && !(hit && sz >= 4 && !acc)) begin
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("tx_req", 512'(tx_req), 512'(m_req));
        if (m_req) chk("tx_data", tx_data, m_data);
        chk("overflow", 512'(overflow), 512'(m_ovf));
        chk("hit_count", 512'(hit_count), 512'(exp_stat(m_hits)));
        chk("drop_count", 512'(drop_count), 512'(exp_stat(m_drops)));
        @(negedge clk);
    endtask

    task automatic idle(input int k, input logic rdy);
        for (int i = 0; i < k; i++) cyc(1'b0, '0, '0, 8'd16, rdy, 1'b0);
    endtask

    initial begin
        logic [255:0] h;
        logic [7:0]   zb;
        logic [31:0]  drops_before;

        rst_n = 1'b0; in_valid = 0; in_hash = '0; in_nonce = '0;
        zero_bits = 8'd16; clr_ovf = 0; tx_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx_req", 512'(tx_req), 512'(0));
        chk("reset_tx_data", tx_data, 512'(0));
        chk("reset_overflow", 512'(overflow), 512'(0));
        chk("reset_hits", 512'(hit_count), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Near miss: only 15 leading zeros against a 16-bit difficulty.
        cyc(1'b1, {16'h0001, 240'h0}, 32'h11111111, 8'd16, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("near_miss_hits", 512'(hit_count), 512'(0));
        chk("near_miss_req", 512'(tx_req), 512'(0));
        // zero_bits = 0 accepts anything.
        cyc(1'b1, {256{1'b1}}, 32'h22222222, 8'd0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("zb0_hit_req", 512'(tx_req), 512'(1));
        idle(3, 1'b1);

        // Basic hit and frame fields.
        cyc(1'b1, {16'h0000, {240{1'b1}}}, 32'hb2957c02, 8'd16, 1'b0, 1'b0);
        chk("latency_req_low", 512'(tx_req), 512'(0));
        idle(1, 1'b0);
        chk("latency_req_high", 512'(tx_req), 512'(1));
        chk("frame_nonce", 512'(tx_data[295:264]), 512'(32'hb2957c02));
        chk("frame_sep0", 512'(tx_data[263:256]), 512'(8'haa));
        chk("frame_magic", 512'(tx_data[511:448]), 512'(64'hdead432987beefaa));
        idle(3, 1'b1);

        // Overflow: six hits into a four-deep queue while stalled.
        dut_sent.delete();
        for (int i = 1; i <= 6; i++) cyc(1'b1, hit_hash(), 32'(i), 8'd16, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("ovf_flag", 512'(overflow), 512'(1));
        chk("ovf_drops", 512'(drop_count), 512'(exp_stat(32'd2)));
        idle(14, 1'b1);
        chk("ovf_sent_cnt", 512'(dut_sent.size()), 512'(4));
        for (int i = 0; i < 4; i++)
            if (i < dut_sent.size()) chk("ovf_sent_order", 512'(dut_sent[i]), 512'(i + 1));

        // Full queue with a hit landing on the same edge as an accept.
        cyc(1'b0, '0, '0, 8'd16, 1'b0, 1'b1);
        dut_sent.delete();
        drops_before = drop_count;
        for (int i = 10; i <= 13; i++) cyc(1'b1, hit_hash(), 32'(i), 8'd16, 1'b0, 1'b0);
        idle(1, 1'b0);
        cyc(1'b1, hit_hash(), 32'd14, 8'd16, 1'b1, 1'b0);
        idle(16, 1'b1);
        chk("same_edge_drops", 512'(drop_count), 512'(drops_before));
        chk("same_edge_sent_cnt", 512'(dut_sent.size()), 512'(5));
        if (dut_sent.size() == 5) chk("same_edge_last", 512'(dut_sent[4]), 512'(14));

        // Randomized traffic including difficulty 255 corner hashes.
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 8; j++) h[j*32 +: 32] = $urandom;
            h  = h >> $urandom_range(0, 20);
            zb = 8'($urandom_range(0, 16));
            if ($urandom_range(0, 15) == 0) begin
                zb = 8'd255;
                h  = 256'($urandom_range(0, 3));
            end
            cyc($urandom_range(0, 2) != 0, h, $urandom, zb,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end
        idle(20, 1'b1);

        // Asynchronous reset while offering with three entries queued.
        for (int i = 20; i < 23; i++) cyc(1'b1, hit_hash(), 32'(i), 8'd16, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("pre_reset_req", 512'(tx_req), 512'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 512'(tx_req), 512'(0));
        chk("async_rst_data", tx_data, 512'(0));
        chk("async_rst_ovf", 512'(overflow), 512'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        dut_sent.delete();
        idle(6, 1'b1);
        chk("post_reset_frames", 512'(dut_sent.size()), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
